// File: rtl/if_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// Holds redirect encodings, FSM states and the IF/ID bundle.
package if_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

    localparam logic [1:0] PCS_SEQ = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_JR  = 2'b10;
    localparam logic [1:0] PCS_J   = 2'b11;

    typedef enum logic [1:0] {
        IF_REQ,
        IF_WAIT,
        IF_HOLD
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus.
// The fetch stage is master; memory is slave.
interface if_stage_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_ack,
        input  inst_rvalid,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_ack,
        output inst_rvalid,
        output inst_rdata
    );

endinterface

// File: rtl/npc_sel.sv
// Next fetch address selection: live redirect, then pending
// redirect, then sequential; result is word aligned.
module npc_sel
    import if_pkg::*;
(
    input  logic [1:0]  pcsource,
    input  logic        redirect,
    input  logic [31:0] bpc,
    input  logic [31:0] jrpc,
    input  logic [31:0] jpc,
    input  logic        pend_valid,
    input  logic [31:0] pend_tgt,
    input  logic [31:0] fetch_pc,
    output logic [31:0] redir_tgt,
    output logic [31:0] npc
);

    logic [31:0] seq_pc;

    always_comb begin
        seq_pc    = fetch_pc + 32'd4;
        redir_tgt = seq_pc;
        unique case (pcsource)
            PCS_SEQ: redir_tgt = seq_pc;
            PCS_BR:  redir_tgt = bpc;
            PCS_JR:  redir_tgt = jrpc;
            PCS_J:   redir_tgt = jpc;
        endcase
        if (redirect) begin
            npc = redir_tgt;
        end else if (pend_valid) begin
            npc = pend_tgt;
        end else begin
            npc = seq_pc;
        end
        npc[1:0] = 2'b00;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding fetch, IF/ID register
// plus one hold buffer, delay-slot aware redirect.
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        id_stall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jrpc,
    input  logic [31:0] jpc,
    if_stage_if.master  bus,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic        o_valid
);

    if_state_e   state;
    if_state_e   state_nxt;
    logic        started;
    logic [31:0] fetch_pc;
    logic        pend_valid;
    logic [31:0] pend_tgt;
    if_id_t      hold;
    if_id_t      ifid;

    logic        consume;
    logic        redirect;
    logic        load_wait;
    logic        load_hold;
    logic        load;
    logic        to_hold;
    logic [31:0] redir_tgt;
    logic [31:0] npc;

    assign consume   = o_valid & ~id_stall;
    assign redirect  = consume & (pcsource != PCS_SEQ);
    assign load_wait = (state == IF_WAIT) & bus.inst_rvalid
                     & (~o_valid | consume);
    assign load_hold = (state == IF_HOLD) & consume;
    assign load      = load_wait | load_hold;
    assign to_hold   = (state == IF_WAIT) & bus.inst_rvalid & ~load_wait;

    // started keeps inst_req low until the first edge after reset
    assign bus.inst_req  = (state == IF_REQ) & started;
    assign bus.inst_addr = fetch_pc;

    assign o_pc   = ifid.pc;
    assign o_inst = ifid.inst;

    npc_sel u_npc_sel (
        .pcsource   (pcsource),
        .redirect   (redirect),
        .bpc        (bpc),
        .jrpc       (jrpc),
        .jpc        (jpc),
        .pend_valid (pend_valid),
        .pend_tgt   (pend_tgt),
        .fetch_pc   (fetch_pc),
        .redir_tgt  (redir_tgt),
        .npc        (npc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IF_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IF_REQ: begin
                if (bus.inst_req && bus.inst_ack) begin
                    state_nxt = IF_WAIT;
                end
            end
            IF_WAIT: begin
                if (load_wait) begin
                    state_nxt = IF_REQ;
                end else if (to_hold) begin
                    state_nxt = IF_HOLD;
                end
            end
            IF_HOLD: begin
                if (load_hold) begin
                    state_nxt = IF_REQ;
                end
            end
            default: state_nxt = IF_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started    <= 1'b0;
            fetch_pc   <= RESET_PC;
            pend_valid <= 1'b0;
            pend_tgt   <= '0;
            hold       <= '0;
            ifid       <= '0;
            o_valid    <= 1'b0;
        end else begin
            started <= 1'b1;
            if (to_hold) begin
                hold <= '{pc: fetch_pc, inst: bus.inst_rdata};
            end
            if (load) begin
                ifid     <= load_hold ? hold
                          : '{pc: fetch_pc, inst: bus.inst_rdata};
                o_valid  <= 1'b1;
                fetch_pc <= npc;
            end else if (consume) begin
                o_valid <= 1'b0;
            end
            // a load here is the delay slot, so the target is used now
            if (load) begin
                pend_valid <= 1'b0;
            end else if (redirect) begin
                pend_valid <= 1'b1;
                pend_tgt   <= redir_tgt;
            end
        end
    end

endmodule
